instr_cache_refill: RTL and testbench

- Instruction-cache miss handler; sits directly upstream of instr_cache_core on its fill side.
- On a fetch miss it stalls the fetch stage, reads one line from the memory bus as eight 32-bit beats, and assembles the beats into a bsize-bit block.
- It then drives bwrite/block_in into the cache core and releases the stall once the core reports a hit.

---
 rtl/instr_cache_refill.sv | 142 ++++++++++++++
 tb/tb_instr_cache_refill.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_cache_refill.sv
// Instruction-cache line refill engine: fetches one line as eight beats into the core.
// Optional perf counters (miss_cnt, cyc_cnt) enabled by defining ICACHE_PERF_CNT_EN.
module instr_cache_refill #(
    parameter int asize = 32,
    parameter int dsize = 32,
    parameter int bbits = 5,
    parameter int bsize = 8 << bbits,
    parameter int beats = bsize / dsize
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             SYS,
    input  logic             fetch_req,
    input  logic [asize-1:0] fetch_addr,
    input  logic             hit1,
    output logic [asize-1:0] core_addr,
    output logic             bwrite,
    output logic [bsize-1:0] block_out,
    output logic             stall,
    output logic             mem_req,
    output logic [asize-1:0] mem_addr,
    input  logic             mem_grant,
    input  logic             mem_rvalid,
    input  logic [dsize-1:0] mem_rdata,
    output logic [31:0]      miss_cnt,
    output logic [31:0]      cyc_cnt
);

    localparam int cw = $clog2(beats);
    localparam int iw = $clog2(bsize);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] REQ   = 3'd1;
    localparam logic [2:0] FILL  = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [asize-1:0] line_q, line_d;
    logic [cw-1:0]    cnt_q, cnt_d;
    logic [bsize-1:0] blk_q, blk_d;
    logic             disc_q, disc_d;
    logic [iw-1:0]    lsb;

    // Beat 0 lands in the MSBs, matching the core's word-0 position.
    assign lsb = iw'((beats - 1 - int'(cnt_q)) * dsize);

    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        cnt_d   = cnt_q;
        blk_d   = blk_q;
        disc_d  = disc_q;
        unique case (state_q)
            IDLE: begin
                if (fetch_req && !hit1 && !SYS) begin
                    line_d  = {fetch_addr[asize-1:bbits], {bbits{1'b0}}};
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem_grant) begin
                    state_d = FILL;
                    cnt_d   = '0;
                    if (SYS) disc_d = 1'b1;
                end else if (SYS) begin
                    state_d = IDLE;
                end
            end
            FILL: begin
                if (SYS) disc_d = 1'b1;
                if (mem_rvalid) begin
                    blk_d[lsb +: dsize] = mem_rdata;
                    cnt_d = cnt_q + cw'(1);
                    if (cnt_q == cw'(beats - 1)) state_d = WRITE;
                end
            end
            WRITE: begin
                if (SYS) disc_d = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                disc_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            line_q  <= '0;
            cnt_q   <= '0;
            blk_q   <= '0;
            disc_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            cnt_q   <= cnt_d;
            blk_q   <= blk_d;
            disc_q  <= disc_d;
        end
    end

    assign core_addr = (state_q == IDLE) ? fetch_addr : line_q;
    assign bwrite    = (state_q == WRITE) && !disc_q && !SYS;
    assign block_out = blk_q;
    assign mem_req   = (state_q == REQ);
    assign mem_addr  = line_q;
    assign stall     = ((state_q == IDLE) && fetch_req && !hit1) ||
                       (state_q != IDLE);

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] miss_cnt_q, miss_cnt_d;
    logic [31:0] cyc_cnt_q, cyc_cnt_d;

    always_comb begin
        miss_cnt_d = miss_cnt_q;
        cyc_cnt_d  = cyc_cnt_q;
        if (state_q == IDLE && state_d == REQ) miss_cnt_d = miss_cnt_q + 32'd1;
        if (stall) cyc_cnt_d = cyc_cnt_q + 32'd1;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            miss_cnt_q <= '0;
            cyc_cnt_q  <= '0;
        end else begin
            miss_cnt_q <= miss_cnt_d;
            cyc_cnt_q  <= cyc_cnt_d;
        end
    end

    assign miss_cnt = miss_cnt_q;
    assign cyc_cnt  = cyc_cnt_q;
`else
    assign miss_cnt = '0;
    assign cyc_cnt  = '0;
`endif

endmodule

// File: tb/tb_instr_cache_refill.sv
// Scoreboard bench for instr_cache_refill: driver queues expected bus
// requests and line writes, a negedge monitor checks them as they appear.
module tb_instr_cache_refill;

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic         SYS = 1'b0;
    logic         fetch_req = 1'b0;
    logic [31:0]  fetch_addr = '0;
    logic         hit1 = 1'b0;
    logic [31:0]  core_addr;
    logic         bwrite;
    logic [255:0] block_out;
    logic         stall;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_grant = 1'b0;
    logic         mem_rvalid = 1'b0;
    logic [31:0]  mem_rdata = '0;
    logic [31:0]  miss_cnt;
    logic [31:0]  cyc_cnt;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int bw_cyc = 0;
    int nbw = 0;

    logic [31:0]  exp_req[$];
    logic [31:0]  exp_wa[$];
    logic [255:0] exp_wb[$];

    instr_cache_refill dut (
        .CLK(CLK), .RESET(RESET), .SYS(SYS),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .hit1(hit1),
        .core_addr(core_addr), .bwrite(bwrite), .block_out(block_out),
        .stall(stall), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_grant(mem_grant), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .miss_cnt(miss_cnt), .cyc_cnt(cyc_cnt)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (mem_req && mem_grant) begin
            if (exp_req.size() == 0) begin
                chk("unexpected_req", 1, 0);
            end else begin
                chk("mem_addr", mem_addr, exp_req.pop_front());
            end
        end
        if (bwrite) begin
            nbw++;
            bw_cyc = cyc;
            if (exp_wa.size() == 0) begin
                chk("unexpected_bwrite", 1, 0);
            end else begin
                chk("wr_core_addr", core_addr, exp_wa.pop_front());
                chk("wr_block", block_out, exp_wb.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // sys_beat < 0 means the line is expected to be written.
    task automatic refill(input logic [31:0] addr, input int gdly,
                          input int gap, input int sys_beat,
                          input logic [31:0] base, input logic [31:0] stp);
        logic [255:0] blk;
        int t0;
        int nreq;
        bit wr;
        int lat;
        wr = (sys_beat < 0);
        lat = 2 + gdly + 8 * (gap + 1);
        blk = '0;
        for (int b = 0; b < 8; b++) blk = {blk[223:0], base + stp * b};
        exp_req.push_back({addr[31:5], 5'b0});
        if (wr) begin
            exp_wa.push_back({addr[31:5], 5'b0});
            exp_wb.push_back(blk);
        end
        fetch_req = 1'b1;
        fetch_addr = addr;
        hit1 = 1'b0;
        SYS = 1'b0;
        t0 = cyc;
        #1;
        chk("miss_stall", stall, 1);
        tick();
        nreq = 0;
        for (int i = 0; i < gdly; i++) begin
            if (mem_req) nreq++;
            tick();
        end
        mem_grant = 1'b1;
        #1;
        if (mem_req) nreq++;
        tick();
        mem_grant = 1'b0;
        chk("req_hold", nreq, gdly + 1);
        for (int b = 0; b < 8; b++) begin
            repeat (gap) tick();
            mem_rvalid = 1'b1;
            mem_rdata = base + stp * b;
            SYS = (b == sys_beat);
            tick();
            mem_rvalid = 1'b0;
            SYS = 1'b0;
        end
        #1;
        chk("write_cycle_bwrite", bwrite, wr);
        chk("write_stall", stall, 1);
        tick();
        chk("done_stall", stall, 1);
        if (wr) chk("bwrite_latency", bw_cyc - t0, lat);
        tick();
        hit1 = 1'b1;
        #1;
        chk("release_stall", stall, 0);
        tick();
        fetch_req = 1'b0;
        hit1 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] exp_miss;
        logic [31:0] exp_cyc;
        int nreq;
`ifdef ICACHE_PERF_CNT_EN
        exp_miss = 32'd2;
        exp_cyc  = 32'd24;
`else
        exp_miss = 32'd0;
        exp_cyc  = 32'd0;
`endif
        repeat (2) tick();
        RESET = 1'b0;
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_bwrite", bwrite, 0);
        chk("rst_block", block_out, 0);
        chk("rst_miss_cnt", miss_cnt, 0);
        chk("rst_cyc_cnt", cyc_cnt, 0);
        tick();

        refill(32'h0000_1044, 0, 0, -1, 32'h1111_1111, 32'h1111_1111);
        chk("blk_msw", block_out[255:224], 32'h1111_1111);
        chk("blk_lsw", block_out[31:0], 32'h8888_8888);
        refill(32'h0000_2F7C, 0, 0, -1, 32'hC0DE_0000, 32'h0000_0001);
        chk("miss_cnt", miss_cnt, exp_miss);
        chk("cyc_cnt", cyc_cnt, exp_cyc);

        fetch_req = 1'b1;
        fetch_addr = 32'h0000_1044;
        hit1 = 1'b1;
        #1;
        chk("hit_stall", stall, 0);
        chk("hit_core_addr", core_addr, 32'h0000_1044);
        nreq = 0;
        repeat (3) begin
            tick();
            if (mem_req || stall) nreq++;
        end
        chk("hit_no_req", nreq, 0);
        chk("hit_miss_cnt", miss_cnt, exp_miss);
        fetch_req = 1'b0;
        hit1 = 1'b0;
        tick();

        refill(32'h8000_00A4, 5, 1, -1, 32'hA000_0000, 32'h0000_0003);

        fetch_req = 1'b1;
        fetch_addr = 32'h0000_3008;
        tick();
        SYS = 1'b1;
        #1;
        chk("sysreq_mem_req", mem_req, 1);
        tick();
        SYS = 1'b0;
        fetch_req = 1'b0;
        #1;
        chk("sysreq_idle_req", mem_req, 0);
        chk("sysreq_idle_stall", stall, 0);
        tick();

        refill(32'h0000_4010, 0, 0, 3, 32'h5000_0000, 32'h0000_0010);

        exp_req.push_back(32'h0000_5000);
        fetch_req = 1'b1;
        fetch_addr = 32'h0000_501C;
        tick();
        mem_grant = 1'b1;
        tick();
        mem_grant = 1'b0;
        for (int b = 0; b < 4; b++) begin
            mem_rvalid = 1'b1;
            mem_rdata = 32'h7700_0000 + b;
            tick();
        end
        RESET = 1'b1;
        mem_rdata = 32'h7700_0004;
        tick();
        RESET = 1'b0;
        mem_rvalid = 1'b0;
        fetch_req = 1'b0;
        #1;
        chk("midrst_stall", stall, 0);
        chk("midrst_mem_req", mem_req, 0);
        chk("midrst_block", block_out, 0);
        chk("midrst_miss_cnt", miss_cnt, 0);
        mem_rvalid = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_rvalid = 1'b0;
        #1;
        chk("stray_block", block_out, 0);
        chk("stray_stall", stall, 0);
        repeat (3) tick();

        chk("bwrite_pulses", nbw, 3);
        chk("req_queue_empty", exp_req.size(), 0);
        chk("wr_queue_empty", exp_wa.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
